// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scanner
// Brief    : 4-digit common-anode seven-segment scan driver with frame-aligned
//            value update and optional leading-zero blanking.
// Revision : 1.0
// ============================================================================
module seven_seg_scanner #(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        enable,
    input  logic        lz_blank,
    output logic [3:0]  digit,
    output logic [3:0]  anode,
    output logic        frame_done
);

    localparam int              c_CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_idx;
    logic [15:0]        r_shown;
    logic [15:0]        r_pending;
    logic               r_pending_valid;
    logic [3:0]         r_digit;
    logic [3:0]         r_anode;
    logic               r_frame_done;

    logic               w_tick;
    logic               w_wrap;
    logic               w_commit;
    logic [3:0]         w_nibble;
    logic               w_blank;
    logic [3:0]         w_anode;

    assign w_tick   = enable && (r_cnt == c_CNT_MAX);
    assign w_wrap   = w_tick && (r_idx == 2'd3);
    // While dark nothing is lit, so staged values may commit immediately.
    assign w_commit = w_wrap || !enable;

    always_comb begin
        w_nibble = r_shown[3:0];
        w_blank  = 1'b0;
        case (r_idx)
            2'd0: begin
                w_nibble = r_shown[3:0];
                w_blank  = 1'b0;
            end
            2'd1: begin
                w_nibble = r_shown[7:4];
                w_blank  = (r_shown[15:4] == 12'h000);
            end
            2'd2: begin
                w_nibble = r_shown[11:8];
                w_blank  = (r_shown[15:8] == 8'h00);
            end
            default: begin
                w_nibble = r_shown[15:12];
                w_blank  = (r_shown[15:12] == 4'h0);
            end
        endcase
    end

    always_comb begin
        w_anode = 4'b1111;
        if (enable && !(lz_blank && w_blank)) begin
            w_anode = ~(4'b0001 << r_idx);
        end
    end

    // Prescaler and digit index
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (!enable) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Staging register; a load on the commit edge bypasses straight to shown.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shown         <= 16'h0000;
            r_pending       <= 16'h0000;
            r_pending_valid <= 1'b0;
        end else begin
            if (load) begin
                r_pending <= value;
            end
            if (w_commit) begin
                r_pending_valid <= 1'b0;
                if (load) begin
                    r_shown <= value;
                end else if (r_pending_valid) begin
                    r_shown <= r_pending;
                end
            end else if (load) begin
                r_pending_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit      <= 4'h0;
            r_anode      <= 4'b1111;
            r_frame_done <= 1'b0;
        end else begin
            r_digit      <= w_nibble;
            r_anode      <= w_anode;
            r_frame_done <= w_wrap;
        end
    end

    assign digit      = r_digit;
    assign anode      = r_anode;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scanner
// Brief    : Directed self-checking bench for seven_seg_scanner (CLK_DIV=4).
// Revision : 1.0
// ============================================================================
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        enable;
    logic        lz_blank;
    logic [3:0]  digit;
    logic [3:0]  anode;
    logic        frame_done;

    int n_cmp  = 0;
    int n_fail = 0;

    seven_seg_scanner #(.CLK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .enable     (enable),
        .lz_blank   (lz_blank),
        .digit      (digit),
        .anode      (anode),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bounded wait until frame_done is seen at a falling edge.
    task automatic wait_fd(input string tag);
        logic found;
        found = 1'b0;
        load  = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) found = 1'b1;
        end
        chk(tag, {15'd0, found}, 16'd1);
    endtask

    // Called just after a frame_done sample; checks one full 16-cycle frame
    // showing exp, optionally issuing loads at iterations k1 and k2.
    task automatic run_frame(input string tag, input logic [15:0] exp, input logic lz,
                             input int k1, input logic [15:0] v1,
                             input int k2, input logic [15:0] v2);
        int         s;
        logic [15:0] upper;
        logic [3:0]  e_dig;
        logic [3:0]  e_an;
        for (int k = 1; k <= 16; k++) begin
            if (k == k1) begin
                load = 1'b1; value = v1;
            end else if (k == k2) begin
                load = 1'b1; value = v2;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            s     = (k - 1) / 4;
            upper = exp >> (4 * s);
            e_dig = upper[3:0];
            e_an  = 4'b1111 ^ (4'b0001 << s);
            if (lz && s != 0 && upper == 16'h0000) e_an = 4'b1111;
            chk($sformatf("%s.k%0d.digit", tag, k), {12'd0, digit}, {12'd0, e_dig});
            chk($sformatf("%s.k%0d.anode", tag, k), {12'd0, anode}, {12'd0, e_an});
            chk($sformatf("%s.k%0d.fd", tag, k), {15'd0, frame_done}, {15'd0, (k == 16)});
        end
        load = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        value    = 16'h0000;
        load     = 1'b0;
        enable   = 1'b0;
        lz_blank = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.anode", {12'd0, anode}, 16'h000F);
        chk("rst.digit", {12'd0, digit}, 16'h0000);
        chk("rst.fd", {15'd0, frame_done}, 16'h0000);

        // First enabled edge after reset lights digit 0
        reset  = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        chk("first.anode", {12'd0, anode}, 16'h000E);
        chk("first.digit", {12'd0, digit}, 16'h0000);

        // Basic scan
        load  = 1'b1;
        value = 16'h1234;
        @(negedge clk);
        wait_fd("wait_1234");
        run_frame("scan1234", 16'h1234, 1'b0, 6, 16'hABCD, 0, 16'h0000);

        // Load during idx=1 must not tear the current frame
        run_frame("tearfree", 16'hABCD, 1'b0, 16, 16'hBEEF, 0, 16'h0000);

        // Load coincident with the commit tick
        chk("coinc.pv", {15'd0, dut.r_pending_valid}, 16'h0000);
        run_frame("beef", 16'hBEEF, 1'b0, 2, 16'h1111, 8, 16'h2222);

        // Last write wins; enable blanking ahead of the sparse values
        lz_blank = 1'b1;
        run_frame("ovw2222", 16'h2222, 1'b1, 3, 16'h0050, 0, 16'h0000);
        run_frame("lz0050", 16'h0050, 1'b1, 3, 16'h0000, 0, 16'h0000);
        run_frame("lz0000", 16'h0000, 1'b1, 0, 16'h0000, 0, 16'h0000);

        // Disable mid-frame
        lz_blank = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("dis.anode", {12'd0, anode}, 16'h000F);
        chk("dis.fd", {15'd0, frame_done}, 16'h0000);
        load  = 1'b1;
        value = 16'h9999;
        @(negedge clk);
        load = 1'b0;
        chk("dis.load_cycle.digit", {12'd0, digit}, 16'h0000);
        @(negedge clk);
        chk("dis.commit.digit", {12'd0, digit}, 16'h0009);
        chk("dis.commit.anode", {12'd0, anode}, 16'h000F);
        chk("dis.commit.pv", {15'd0, dut.r_pending_valid}, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("dis.idle%0d.fd", i), {15'd0, frame_done}, 16'h0000);
        end
        chk("dis.idle.anode", {12'd0, anode}, 16'h000F);

        // Re-enable: scan restarts at digit 0
        enable = 1'b1;
        run_frame("reen9999", 16'h9999, 1'b0, 0, 16'h0000, 0, 16'h0000);

        // Reset mid-scan with a pending load outstanding at idx=2
        load  = 1'b1;
        value = 16'h5678;
        @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst.anode", {12'd0, anode}, 16'h000F);
        chk("mrst.digit", {12'd0, digit}, 16'h0000);
        chk("mrst.fd", {15'd0, frame_done}, 16'h0000);
        chk("mrst.pv", {15'd0, dut.r_pending_valid}, 16'h0000);
        reset = 1'b0;
        wait_fd("wait_after_rst");
        run_frame("post_rst", 16'h0000, 1'b0, 0, 16'h0000, 0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
